uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and oversampling constants.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int START_MID  = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 so an idle-high line reads idle.
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, LSB first. Define RX_PARITY_EN to add a parity bit,
// the parity_err port and the PARITY_ODD check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
`ifdef RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    // Tick counter must reach SB_TICK-1 for 1.5/2 stop bits, so it widens beyond 4 bits.
    localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
    localparam int N_W = $clog2(DBIT + 1);

    localparam logic [S_W-1:0] S_MID  = S_W'(START_MID);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

    logic rx_s;

    rx_state_t       state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
`ifdef RX_PARITY_EN
    logic            perr_pend_q, perr_pend_d;
    logic            perr_q, perr_d;
`endif

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            dout_q      <= '0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
`ifdef RX_PARITY_EN
            perr_pend_q <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
`ifdef RX_PARITY_EN
            perr_pend_q <= perr_pend_d;
            perr_q      <= perr_d;
`endif
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        dout_d      = dout_q;
        done_d      = 1'b0;
        ferr_d      = ferr_q;
`ifdef RX_PARITY_EN
        perr_pend_d = perr_pend_q;
        perr_d      = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        // A line back high at mid-start is a glitch, not a frame.
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        n_d = n_q + 1'b1;
                        if (n_q == N_LAST) begin
`ifdef RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        perr_pend_d = rx_s ^ (^b_q) ^ 1'(PARITY_ODD);
                        state_d     = STOP;
                        s_d         = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        done_d  = 1'b1;
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
`ifdef RX_PARITY_EN
                        perr_d  = perr_pend_q;
`endif
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
`ifdef RX_PARITY_EN
    assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (8 data bits, 1 stop bit, s_tick every 4 clk).
module tb_uart_rx;

    localparam int PARITY_ODD = 0;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
`ifdef RX_PARITY_EN
    logic       parity_err;
`else
    logic       parity_err = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int d0;
    int k;
    logic [7:0] hist_dout[$];
    int         hist_cyc[$];

    uart_rx #(
        .DBIT       (8),
        .SB_TICK    (16),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
`ifdef RX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            done_cnt <= done_cnt + 1;
            hist_dout.push_back(dout);
            hist_cyc.push_back(cyc);
        end
    end

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            #1 s_tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (s_tick !== 1'b1);
        end
        #2;
    endtask

    task automatic send_bit(input logic b, input int t);
        rx = b;
        wait_ticks(t);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int stop_ticks);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
`ifdef RX_PARITY_EN
        send_bit(par, 16);
`endif
        send_bit(stop, stop_ticks);
        rx = 1'b1;
    endtask

    function automatic logic epar(input logic [7:0] d);
        return (^d) ^ 1'(PARITY_ODD);
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_done", rx_done_tick, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        reset = 1'b0;
        wait_ticks(4);

        // Clean 8N1 frame.
        d0 = done_cnt;
        send_frame(8'h55, epar(8'h55), 1'b1, 16);
        wait_ticks(4);
        check("55_pulses", done_cnt - d0, 1);
        check("55_dout", dout, 8'h55);
        check("55_ferr", frame_err, 1'b0);

        // Start-bit glitch of 5 ticks is rejected at mid-start.
        d0 = done_cnt;
        send_bit(1'b0, 5);
        send_bit(1'b1, 20);
        check("glitch_pulses", done_cnt - d0, 0);
        check("glitch_dout", dout, 8'h55);

        // Low stop bit; line released early so the tail is seen as a glitch.
        d0 = done_cnt;
        send_frame(8'hA3, epar(8'hA3), 1'b0, 12);
        wait_ticks(24);
        check("a3_pulses", done_cnt - d0, 1);
        check("a3_dout", dout, 8'hA3);
        check("a3_ferr", frame_err, 1'b1);

        // Reset after 4 data bits of 0xFF aborts the frame.
        d0 = done_cnt;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_dout", dout, 8'h00);
        check("rstmid_ferr", frame_err, 1'b0);
        reset = 1'b0;
        wait_ticks(20);
        check("rstmid_pulses", done_cnt - d0, 0);
        d0 = done_cnt;
        send_frame(8'h3C, epar(8'h3C), 1'b1, 16);
        wait_ticks(4);
        check("3c_pulses", done_cnt - d0, 1);
        check("3c_dout", dout, 8'h3C);

        // Back-to-back frames with no idle gap.
        d0 = done_cnt;
        k  = hist_dout.size();
        send_frame(8'h12, epar(8'h12), 1'b1, 16);
        send_frame(8'h34, epar(8'h34), 1'b1, 16);
        wait_ticks(4);
        check("b2b_pulses", done_cnt - d0, 2);
        check("b2b_first", hist_dout[k], 8'h12);
        check("b2b_second", hist_dout[k+1], 8'h34);
        check("b2b_spacing", hist_cyc[k+1] - hist_cyc[k], 640);

`ifdef RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 16);
        wait_ticks(4);
        check("par_ok_dout", dout, 8'h07);
        check("par_ok_perr", parity_err, 1'b0);
        send_frame(8'h07, 1'b0, 1'b1, 16);
        wait_ticks(4);
        check("par_bad_perr", parity_err, 1'b1);
        check("par_bad_ferr", frame_err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
